// File: rtl/dsky_render_pkg.sv
// dsky_render_pkg: shared constants, segment geometry and glyph table for the DSKY digit renderer
// Contents: timing origin, grid placement and size, colours, cell count, character codes,
// segment rectangle bounds (half-open, cell-local), seg_mask(code) -> {p,g,f,e,d,c,b,a}.
package dsky_render_pkg;
  localparam logic [15:0] H_START = 16'd182;
  localparam logic [15:0] V_START = 16'd0;
  localparam logic [15:0] GRID_X0 = 16'd144;
  localparam logic [15:0] GRID_Y0 = 16'd48;
  localparam logic [15:0] GRID_W = 16'd512;
  localparam logic [15:0] GRID_H = 16'd384;
  localparam logic [15:0] CELL_W = 16'd64;
  localparam logic [15:0] CELL_H = 16'd128;
  localparam logic [15:0] FG = 16'h07E0;
  localparam logic [15:0] BG = 16'h0000;
  localparam logic [4:0] N_CELLS = 5'd24;
  localparam logic [3:0] CH_PLUS = 4'd10;
  localparam logic [3:0] CH_MINUS = 4'd11;
  localparam logic [3:0] CH_BLANK = 4'd15;
  localparam logic [6:0] H_X0 = 7'd16, H_X1 = 7'd48;
  localparam logic [6:0] L_X0 = 7'd8, L_X1 = 7'd16;
  localparam logic [6:0] R_X0 = 7'd48, R_X1 = 7'd56;
  localparam logic [6:0] P_X0 = 7'd28, P_X1 = 7'd36;
  localparam logic [6:0] A_Y0 = 7'd8, A_Y1 = 7'd16;
  localparam logic [6:0] G_Y0 = 7'd60, G_Y1 = 7'd68;
  localparam logic [6:0] D_Y0 = 7'd112, D_Y1 = 7'd120;
  localparam logic [6:0] U_Y0 = 7'd16, U_Y1 = 7'd60;
  localparam logic [6:0] W_Y0 = 7'd68, W_Y1 = 7'd112;
  localparam logic [6:0] P_Y0 = 7'd36, P_Y1 = 7'd92;
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'hC0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00
  };
  function automatic logic [7:0] seg_mask(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction
  function automatic logic in_span(input logic [6:0] v, input logic [6:0] lo, input logic [6:0] hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/dsky_digit_renderer_if.sv
// dsky_digit_renderer_if: character-bank write/commit bus of the DSKY renderer
// wr_en/wr_addr/wr_data write the pending bank, commit requests a frame-boundary swap;
// swap_pending and frame_swap report swap status back to the host.
interface dsky_digit_renderer_if;
  logic wr_en;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic commit;
  logic swap_pending;
  logic frame_swap;
  modport master(output wr_en, wr_addr, wr_data, commit, input swap_pending, frame_swap);
  modport slave(input wr_en, wr_addr, wr_data, commit, output swap_pending, frame_swap);
endinterface

// File: rtl/dsky_seg_hit.sv
// dsky_seg_hit: combinational test of a cell-local pixel against the lit segments of a glyph
// cx/cy: position inside the 64x128 cell; mask: {p,g,f,e,d,c,b,a}; hit: pixel lies in a lit segment.
module dsky_seg_hit
  import dsky_render_pkg::*;
(
  input  logic [5:0] cx,
  input  logic [6:0] cy,
  input  logic [7:0] mask,
  output logic       hit
);
  logic [6:0] x;
  logic [7:0] seg;
  assign x = {1'b0, cx};
  assign seg = {
    in_span(x, P_X0, P_X1) && in_span(cy, P_Y0, P_Y1),
    in_span(x, H_X0, H_X1) && in_span(cy, G_Y0, G_Y1),
    in_span(x, L_X0, L_X1) && in_span(cy, U_Y0, U_Y1),
    in_span(x, L_X0, L_X1) && in_span(cy, W_Y0, W_Y1),
    in_span(x, H_X0, H_X1) && in_span(cy, D_Y0, D_Y1),
    in_span(x, R_X0, R_X1) && in_span(cy, W_Y0, W_Y1),
    in_span(x, R_X0, R_X1) && in_span(cy, U_Y0, U_Y1),
    in_span(x, H_X0, H_X1) && in_span(cy, A_Y0, A_Y1)
  };
  assign hit = |(seg & mask);
endmodule

// File: rtl/dsky_digit_renderer.sv
// dsky_digit_renderer: renders a 3x8 grid of DSKY 7-segment characters as RGB565 with frame-synchronous bank swap
// PixelClk/nRST: clock and async active-low reset; PixelCount/LineCount, in_de/in_hsync/in_vsync: timing
// generator inputs; bus: pending-bank write/commit port; LCD_*: strobes and colour, 3 cycles behind the inputs.
module dsky_digit_renderer
  import dsky_render_pkg::*;
(
  input  logic                         PixelClk,
  input  logic                         nRST,
  input  logic [15:0]                  PixelCount,
  input  logic [15:0]                  LineCount,
  input  logic                         in_de,
  input  logic                         in_hsync,
  input  logic                         in_vsync,
  dsky_digit_renderer_if.slave         bus,
  output logic                         LCD_DE,
  output logic                         LCD_HSYNC,
  output logic                         LCD_VSYNC,
  output logic [4:0]                   LCD_R,
  output logic [5:0]                   LCD_G,
  output logic [4:0]                   LCD_B
);
  logic [23:0][3:0] pending, display;
  logic [15:0] gx, gy, rgb;
  logic vs_prev, swap;
  logic s1_in, s2_hit, hit;
  logic [4:0] s1_idx;
  logic [5:0] s1_cx;
  logic [6:0] s1_cy;
  logic [3:0] code;
  logic [2:0] de_sr, hs_sr, vs_sr;
  assign gx = PixelCount - H_START - GRID_X0;
  assign gy = LineCount - V_START - GRID_Y0;
  assign swap = vs_prev & ~in_vsync & bus.swap_pending;
  assign code = s1_idx < N_CELLS ? display[s1_idx] : CH_BLANK;
  dsky_seg_hit u_seg_hit (.cx(s1_cx), .cy(s1_cy), .mask(seg_mask(code)), .hit(hit));
  // The bank copy uses the pre-write pending value, so a same-cycle write only lands in pending.
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      pending <= '1;
      display <= '1;
      vs_prev <= 1'b1;
      bus.swap_pending <= 1'b0;
      bus.frame_swap <= 1'b0;
    end else begin
      if (bus.wr_en && bus.wr_addr < N_CELLS) pending[bus.wr_addr] <= bus.wr_data;
      if (swap) display <= pending;
      vs_prev <= in_vsync;
      bus.swap_pending <= !swap && (bus.swap_pending || bus.commit);
      bus.frame_swap <= swap;
    end
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      s1_in <= 1'b0;
      s1_idx <= '0;
      s1_cx <= '0;
      s1_cy <= '0;
      s2_hit <= 1'b0;
      rgb <= '0;
      de_sr <= '0;
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      s1_in <= gx < GRID_W && gy < GRID_H;
      s1_idx <= {gy[8:7], gx[8:6]};
      s1_cx <= gx[5:0];
      s1_cy <= gy[6:0];
      s2_hit <= s1_in & hit;
      rgb <= de_sr[1] ? (s2_hit ? FG : BG) : 16'h0000;
      de_sr <= {de_sr[1:0], in_de};
      hs_sr <= {hs_sr[1:0], in_hsync};
      vs_sr <= {vs_sr[1:0], in_vsync};
    end
  assign LCD_DE = de_sr[2];
  assign LCD_HSYNC = hs_sr[2];
  assign LCD_VSYNC = vs_sr[2];
  assign {LCD_R, LCD_G, LCD_B} = rgb;
endmodule

// File: tb/tb_dsky_digit_renderer.sv
// tb_dsky_digit_renderer: directed and random stimulus against a glyph-level model of the DSKY renderer
module tb_dsky_digit_renderer;
  logic PixelClk = 1'b0;
  logic nRST = 1'b0;
  logic [15:0] PixelCount = '0, LineCount = '0;
  logic in_de = 1'b0, in_hsync = 1'b1, in_vsync = 1'b1;
  logic LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;
  dsky_digit_renderer_if bus();
  dsky_digit_renderer dut (
    .PixelClk(PixelClk), .nRST(nRST), .PixelCount(PixelCount), .LineCount(LineCount),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync), .bus(bus),
    .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
  );
  always #5 PixelClk = ~PixelClk;
  int checks = 0, errors = 0;
  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "gp", "g", "", "", "", ""};
  int m_disp [24], m_bank [24];
  bit m_pend, m_fs, m_vprev;
  bit hs_v = 1'b1, vs_v = 1'b1;
  logic [18:0] q[$];
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [18:0] IDLE = {1'b0, 1'b1, 1'b1, 16'h0000};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit span(input int v, input int lo, input int hi);
    return v >= lo && v < hi;
  endfunction
  function automatic bit lit(input int code, input int cx, input int cy);
    string s = segs[code];
    bit r = 1'b0;
    bit h;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": h = span(cx, 16, 48) && span(cy, 8, 16);
        "b": h = span(cx, 48, 56) && span(cy, 16, 60);
        "c": h = span(cx, 48, 56) && span(cy, 68, 112);
        "d": h = span(cx, 16, 48) && span(cy, 112, 120);
        "e": h = span(cx, 8, 16) && span(cy, 68, 112);
        "f": h = span(cx, 8, 16) && span(cy, 16, 60);
        "g": h = span(cx, 16, 48) && span(cy, 60, 68);
        "p": h = span(cx, 28, 36) && span(cy, 36, 92);
        default: h = 1'b0;
      endcase
      r = r | h;
    end
    return r;
  endfunction
  function automatic logic [15:0] pix_rgb(input int px, input int ln, input bit de);
    int gx = (px - 182 - 144) & 'hFFFF;
    int gy = (ln - 0 - 48) & 'hFFFF;
    if (!de || gx >= 512 || gy >= 384) return 16'h0000;
    return lit(m_disp[(gy / 128) * 8 + gx / 64], gx % 64, gy % 128) ? GREEN : 16'h0000;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 24; i++) begin
      m_disp[i] = 15;
      m_bank[i] = 15;
    end
    m_pend = 1'b0;
    m_fs = 1'b0;
    m_vprev = 1'b1;
    q.delete();
    q.push_back(IDLE);
    q.push_back(IDLE);
  endtask
  task automatic step(input int px, input int ln, input bit de);
    bit sw;
    PixelCount = 16'(px);
    LineCount = 16'(ln);
    in_de = de;
    in_hsync = hs_v;
    in_vsync = vs_v;
    sw = m_vprev && !vs_v && m_pend;
    if (sw) m_disp = m_bank;
    if (bus.wr_en && bus.wr_addr < 24) m_bank[bus.wr_addr] = int'(bus.wr_data);
    if (sw) m_pend = 1'b0;
    else if (bus.commit) m_pend = 1'b1;
    m_fs = sw;
    m_vprev = vs_v;
    q.push_back({de, hs_v, vs_v, pix_rgb(px, ln, de)});
    @(posedge PixelClk);
    @(negedge PixelClk);
    bus.wr_en = 1'b0;
    bus.commit = 1'b0;
    check("pipe", {LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B}, q.pop_front());
    check("swap_pending", bus.swap_pending, m_pend);
    check("frame_swap", bus.frame_swap, m_fs);
  endtask
  task automatic write(input int addr, input int data);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(addr);
    bus.wr_data = 4'(data);
    step(0, 0, 1'b0);
  endtask
  task automatic commit_now();
    bus.commit = 1'b1;
    step(0, 0, 1'b0);
  endtask
  task automatic vpulse();
    vs_v = 1'b0;
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    vs_v = 1'b1;
    step(0, 0, 1'b0);
  endtask
  task automatic probe(input string tag, input int gx, input int gy, input logic [15:0] exp);
    step(gx + 326, gy + 48, 1'b1);
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    check(tag, {LCD_R, LCD_G, LCD_B}, exp);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_de"}, LCD_DE, 1'b0);
    check({tag, "_hs"}, LCD_HSYNC, 1'b1);
    check({tag, "_vs"}, LCD_VSYNC, 1'b1);
    check({tag, "_rgb"}, {LCD_R, LCD_G, LCD_B}, 16'h0000);
    check({tag, "_pend"}, bus.swap_pending, 1'b0);
    check({tag, "_fswap"}, bus.frame_swap, 1'b0);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit = 1'b0;
    model_reset();
    repeat (3) @(negedge PixelClk);
    check_idle("reset");
    nRST = 1'b1;
    for (int i = 0; i < 300; i++) begin
      hs_v = ($urandom_range(0, 9) != 0);
      step(326 + $urandom_range(0, 520), 48 + $urandom_range(0, 390), 1'(($urandom_range(0, 3) != 0)));
    end
    hs_v = 1'b1;
    vpulse();
    write(0, 8);
    commit_now();
    check("pend_after_commit", bus.swap_pending, 1'b1);
    probe("pre_swap_blank", 20, 10, 16'h0000);
    vpulse();
    probe("seg_a_lit", 20, 10, GREEN);
    check("seg_a_green", LCD_G, 6'h3F);
    check("seg_a_red_blue", {LCD_R, LCD_B}, 10'h000);
    probe("code8_hole", 30, 30, 16'h0000);
    write(9, 10);
    commit_now();
    vpulse();
    probe("plus_bar", 96, 200, GREEN);
    write(9, 11);
    commit_now();
    vpulse();
    probe("minus_no_bar", 96, 200, 16'h0000);
    bus.commit = 1'b1;
    vs_v = 1'b0;
    step(0, 0, 1'b0);
    check("commit_at_edge_pend", bus.swap_pending, 1'b1);
    check("commit_at_edge_no_swap", bus.frame_swap, 1'b0);
    step(0, 0, 1'b0);
    vs_v = 1'b1;
    step(0, 0, 1'b0);
    vs_v = 1'b0;
    step(0, 0, 1'b0);
    check("next_edge_swap", bus.frame_swap, 1'b1);
    vs_v = 1'b1;
    step(0, 0, 1'b0);
    write(24, 8);
    commit_now();
    vpulse();
    for (int c = 0; c < 24; c++)
      probe($sformatf("cell%0d_after_bad_addr", c), (c % 8) * 64 + 20, (c / 8) * 128 + 10,
            c == 0 ? GREEN : 16'h0000);
    for (int i = 0; i < 500; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 6) begin
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'($urandom_range(0, 31));
        bus.wr_data = 4'($urandom_range(0, 15));
      end
      if (r == 6) bus.commit = 1'b1;
      if (r == 7 || r == 8) vs_v = !vs_v;
      hs_v = ($urandom_range(0, 7) != 0);
      step(326 + $urandom_range(0, 520), 48 + $urandom_range(0, 390), 1'($urandom_range(0, 1)));
    end
    hs_v = 1'b1;
    vs_v = 1'b1;
    step(0, 0, 1'b0);
    write(0, 8);
    commit_now();
    vpulse();
    hs_v = 1'b0;
    repeat (3) step(20 + 326, 10 + 48, 1'b1);
    check("pre_reset_lit", {LCD_DE, LCD_R, LCD_G, LCD_B}, {1'b1, GREEN});
    #2 nRST = 1'b0;
    #1 check_idle("midline_reset");
    hs_v = 1'b1;
    @(negedge PixelClk);
    nRST = 1'b1;
    model_reset();
    probe("post_reset_blank", 20, 10, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsky_digit_renderer.md
# dsky_digit_renderer

Pixel-colour stage driven by the LCD timing generator. It takes the raw pixel/line counters and sync/DE strobes and renders a 3×8 grid of DSKY 7-segment characters as RGB565. Sync and DE are delayed to stay aligned with the colour pipeline. Character codes are written into a pending bank and committed to the display bank only at a frame boundary, so the panel never shows a half-updated frame.

## Interface
- H_START, 182: PixelCount of the first active pixel (x = 0).
- V_START, 0: LineCount of the first active line (y = 0).
- GRID_X0, 144: x of the grid's left edge, in active coordinates.
- GRID_Y0, 48: y of the grid's top edge, in active coordinates.
- FG, 16'h07E0: lit-segment colour (RGB565).
- BG, 16'h0000: unlit and background colour.
- PixelClk  in  1  pixel clock; all logic on its rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- PixelCount  in  16  horizontal counter from the timing generator.
- LineCount  in  16  vertical counter from the timing generator.
- in_de, in_hsync, in_vsync  in  1 each  timing strobes; both syncs are active-low.
- wr_en  in  1  write strobe for the pending bank.
- wr_addr  in  5  cell index, row*8+col, valid range 0..23.
- wr_data  in  4  character code.
- commit  in  1  one-cycle request to swap the pending bank to display.
- swap_pending  out  1  a commit is waiting for the next frame boundary.
- frame_swap  out  1  one-cycle pulse on the cycle the bank copy happens.
- LCD_DE, LCD_HSYNC, LCD_VSYNC  out  1 each  strobes delayed by 3 cycles.
- LCD_R  out  5  red; LCD_G  out  6  green; LCD_B  out  5  blue.

## Operation
- Coordinates:
  - x = PixelCount − H_START and y = LineCount − V_START, computed in 16-bit.
  - gx = x − GRID_X0 and gy = y − GRID_Y0.
  - A pixel is in the grid iff 0 ≤ gx < 512 and 0 ≤ gy < 384; negative values wrap to large unsigned and fall outside.
- Cells are 64×128: col = gx[8:6], row = gy[8:7], cx = gx[5:0], cy = gy[6:0]. Cell index = row*8+col.
- Segments are half-open rectangles within the cell:
  - Horizontal segments span cx∈[16,48): a at cy∈[8,16), g at cy∈[60,68), d at cy∈[112,120).
  - f: cx∈[8,16), cy∈[16,60). b: cx∈[48,56), cy∈[16,60).
  - e: cx∈[8,16), cy∈[68,112). c: cx∈[48,56), cy∈[68,112).
  - p (plus bar): cx∈[28,36), cy∈[36,92).
- Character codes:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg.
  - 10 '+' = g and p. 11 '−' = g.
  - 12–15 blank.
- Pixel colour is FG if in the grid and any lit segment of the cell's code contains (cx, cy); otherwise BG. When the delayed DE is low, RGB is forced to 0.
- Banks:
  - pending[0..23] and display[0..23], 4 bits each.
  - wr_en with wr_addr ≤ 23 writes pending. wr_addr ≥ 24 is ignored.
  - commit sets swap_pending. A commit while swap_pending is already 1 has no further effect.
- Swap:
  - Trigger: falling edge of in_vsync (registered previous value is 1, current value is 0) while swap_pending = 1.
  - Action: display ← pending, swap_pending clears, frame_swap pulses for one cycle.
- Simultaneous events:
  - Write and swap in the same cycle: display takes the pre-write pending contents; the write still lands in pending.
  - commit in the same cycle as the vsync falling edge: no swap this frame; swap_pending is set and the swap happens at the next frame.
- Reset: both banks = 4'hF (blank); swap_pending = 0; frame_swap = 0; RGB = 0; LCD_DE = 0; LCD_HSYNC = LCD_VSYNC = 1; all pipeline registers cleared to those same idle values. Asserting reset mid-frame returns to this state immediately; the first frame after reset shows blank.

## Timing
- 3-stage pipeline:
  - S1 registers coordinates, in-grid flag, cell index, cx and cy.
  - S2 reads display[index] and registers the segment-hit vector.
  - S3 registers RGB.
- Latency from counters to RGB is exactly 3 PixelClk cycles. The three strobes pass through a matching 3-deep shift register.
- The display-bank read in S2 uses the bank value as of that cycle, so a swap takes effect on pixels whose S2 falls after the swap cycle. The swap occurs in vsync, outside active video.
- swap_pending rises the cycle after commit. frame_swap is asserted in the cycle after the vsync edge is sampled.

## Structure
- Package dsky_render_pkg:
  - segment rectangle bounds, cell size and grid size constants;
  - the character-code localparams;
  - a 4→8 function seg_mask(code) returning {p,g,f,e,d,c,b,a}.
- Sub-module dsky_seg_hit: combinational (cx, cy, mask) → hit, instantiated in S2. Everything else stays in dsky_digit_renderer.

## Test plan
- Reset then drive one full frame: RGB = 0 at every DE-high pixel; HSYNC/VSYNC match the inputs delayed by 3 cycles.
- Write code 8 to cell 0, commit: before the next vsync falling edge the display stays blank. In the following frame, pixel (gx=20, gy=10) gives R=0, G=6'h3F, B=0, and (gx=30, gy=30) gives RGB = 0.
- Code 10 to cell 9 (row 1, col 1): pixel (gx=96, gy=200), i.e. cx=32, cy=72 (p only) → FG; same cell with code 11 → BG.
- commit asserted in the same cycle as the vsync falling edge: swap_pending = 1 and no frame_swap; frame_swap pulses at the next frame's edge.
- wr_addr = 24 with wr_data = 8, commit, one frame: all 24 cells unchanged.
- Assert nRST mid-line after a swap: outputs go to idle values the same cycle, and the display is blank afterwards.
